// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment digit sequencer:
//   - seq_state_t : sequencer FSM states (EMPTY, HOLD, SHOW, GAP)
//   - SEG_TABLE   : 16-entry hex-to-segment table, active-high, bit 0 = a
//   - BLANK_SEG   : all segments off
// No ports (package).
// ---------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_SHOW  = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_t;

  localparam logic [6:0] BLANK_SEG = 7'h00;

  // Segment patterns for 0..F (lowercase b and d keep them distinct from 8 and 0)
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational nibble-to-segments decoder (full hex 0..F).
// Ports:
//   nibble [3:0] in  : value to decode
//   seg    [6:0] out : segments a..g, active-high, bit 0 = a
// ---------------------------------------------------------------------------
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_digit_sequencer.sv
// ---------------------------------------------------------------------------
// seg7_digit_sequencer
// Captures up to DEPTH hex digits into a buffer and scans them onto a single
// seven-segment display with a programmable per-digit dwell time.
//
// Optional feature macro: SEQ_BLANK_GAP_EN
//   defined   : a blank GAP state of GAP cycles follows each digit, so repeated
//               identical digits show as separate blinks.
//   undefined : SHOW steps straight to the next digit; no gap logic exists.
//
// Ports:
//   io_in[0]    clock (rising edge)
//   io_in[1]    reset, synchronous, active-high
//   io_in[2]    wr load strobe (acts on its rising edge)
//   io_in[3]    run: 1 scans the buffer, 0 holds on the last written digit
//   io_in[7:4]  digit nibble
//   io_out[6:0] segments a..g, active-high, bit 0 = a (registered)
//   io_out[7]   full: buffer holds DEPTH digits (registered)
// ---------------------------------------------------------------------------
module seg7_digit_sequencer
  import seg7_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DWELL = 1000
`ifdef SEQ_BLANK_GAP_EN
  ,
  parameter int GAP   = 250
`endif
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef SEQ_BLANK_GAP_EN
  localparam int TMAX  = (DWELL > GAP) ? DWELL : GAP;
`else
  localparam int TMAX  = DWELL;
`endif
  // At least one bit so DWELL=1 still yields a legal counter
  localparam int TIM_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [TIM_W-1:0] DWELL_LAST = TIM_W'(DWELL - 1);
`ifdef SEQ_BLANK_GAP_EN
  localparam logic [TIM_W-1:0] GAP_LAST   = TIM_W'(GAP - 1);
`endif

  logic             clk_s;
  logic             rst_s;
  logic             wr_s;
  logic             run_s;
  logic [3:0]       nib_s;

  assign clk_s = io_in[0];
  assign rst_s = io_in[1];
  assign wr_s  = io_in[2];
  assign run_s = io_in[3];
  assign nib_s = io_in[7:4];

  seq_state_t       state_r;
  seq_state_t       state_nx_s;
  logic             wr_q_r;
  logic [CNT_W-1:0] count_r;
  logic [3:0]       last_r;
  logic [3:0]       digit_buf_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_nx_s;
  logic [TIM_W-1:0] dwell_cnt_r;
  logic [TIM_W-1:0] dwell_nx_s;
`ifdef SEQ_BLANK_GAP_EN
  logic [TIM_W-1:0] gap_cnt_r;
  logic [TIM_W-1:0] gap_nx_s;
`endif
  logic [7:0]       io_out_r;

  logic             write_ev_s;
  logic             write_ok_s;
  logic             full_s;
  logic [CNT_W-1:0] ptr_plus_s;
  logic [PTR_W-1:0] ptr_wrap_s;
  logic [3:0]       disp_nib_s;
  logic             blank_s;
  logic [6:0]       dec_seg_s;
  logic [6:0]       seg_s;

  assign write_ev_s = wr_s & ~wr_q_r;
  assign full_s     = (count_r == DEPTH_C);
  assign write_ok_s = write_ev_s & ~run_s & (count_r < DEPTH_C);

  // Next read pointer wraps at the number of stored digits, not at DEPTH
  assign ptr_plus_s = {1'b0, rd_ptr_r} + CNT_W'(1);
  assign ptr_wrap_s = (ptr_plus_s >= count_r) ? {PTR_W{1'b0}} : ptr_plus_s[PTR_W-1:0];

  // Strobe history for rising-edge detection; reset high so a held strobe is not a write
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      wr_q_r <= 1'b1;
    end else begin
      wr_q_r <= wr_s;
    end
  end

  // Digit buffer, fill count and most recently written digit
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      count_r <= {CNT_W{1'b0}};
      last_r  <= 4'h0;
      for (int i = 0; i < DEPTH; i++) begin
        digit_buf_r[i] <= 4'h0;
      end
    end else if (write_ok_s) begin
      digit_buf_r[count_r[PTR_W-1:0]] <= nib_s;
      count_r <= count_r + CNT_W'(1);
      last_r  <= nib_s;
    end else begin
      count_r <= count_r;
    end
  end

  // Next-state, read pointer and timer logic; dropping run beats timer expiry
  always_comb begin
    state_nx_s  = state_r;
    rd_ptr_nx_s = rd_ptr_r;
    dwell_nx_s  = dwell_cnt_r;
`ifdef SEQ_BLANK_GAP_EN
    gap_nx_s    = gap_cnt_r;
`endif
    case (state_r)
      ST_EMPTY: begin
        if (write_ok_s) begin
          state_nx_s = ST_HOLD;
        end else begin
          state_nx_s = ST_EMPTY;
        end
      end
      ST_HOLD: begin
        if (run_s) begin
          state_nx_s  = ST_SHOW;
          rd_ptr_nx_s = {PTR_W{1'b0}};
          dwell_nx_s  = {TIM_W{1'b0}};
        end else begin
          state_nx_s  = ST_HOLD;
        end
      end
      ST_SHOW: begin
        if (!run_s) begin
          state_nx_s  = ST_HOLD;
          rd_ptr_nx_s = {PTR_W{1'b0}};
          dwell_nx_s  = {TIM_W{1'b0}};
        end else if (dwell_cnt_r == DWELL_LAST) begin
          rd_ptr_nx_s = ptr_wrap_s;
          dwell_nx_s  = {TIM_W{1'b0}};
`ifdef SEQ_BLANK_GAP_EN
          state_nx_s  = ST_GAP;
          gap_nx_s    = {TIM_W{1'b0}};
`else
          state_nx_s  = ST_SHOW;
`endif
        end else begin
          dwell_nx_s  = dwell_cnt_r + TIM_W'(1);
        end
      end
`ifdef SEQ_BLANK_GAP_EN
      ST_GAP: begin
        if (!run_s) begin
          state_nx_s  = ST_HOLD;
          rd_ptr_nx_s = {PTR_W{1'b0}};
          dwell_nx_s  = {TIM_W{1'b0}};
          gap_nx_s    = {TIM_W{1'b0}};
        end else if (gap_cnt_r == GAP_LAST) begin
          state_nx_s  = ST_SHOW;
          gap_nx_s    = {TIM_W{1'b0}};
        end else begin
          gap_nx_s    = gap_cnt_r + TIM_W'(1);
        end
      end
`endif
      default: begin
        state_nx_s  = ST_EMPTY;
        rd_ptr_nx_s = {PTR_W{1'b0}};
        dwell_nx_s  = {TIM_W{1'b0}};
      end
    endcase
  end

  // FSM state, read pointer and timers
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_r     <= ST_EMPTY;
      rd_ptr_r    <= {PTR_W{1'b0}};
      dwell_cnt_r <= {TIM_W{1'b0}};
`ifdef SEQ_BLANK_GAP_EN
      gap_cnt_r   <= {TIM_W{1'b0}};
`endif
    end else begin
      state_r     <= state_nx_s;
      rd_ptr_r    <= rd_ptr_nx_s;
      dwell_cnt_r <= dwell_nx_s;
`ifdef SEQ_BLANK_GAP_EN
      gap_cnt_r   <= gap_nx_s;
`endif
    end
  end

  // Select the digit to show for the current state, or blank
  always_comb begin
    disp_nib_s = last_r;
    blank_s    = 1'b0;
    case (state_r)
      ST_EMPTY: blank_s    = 1'b1;
      ST_HOLD:  disp_nib_s = last_r;
      ST_SHOW:  disp_nib_s = digit_buf_r[rd_ptr_r];
      ST_GAP:   blank_s    = 1'b1;
      default:  blank_s    = 1'b1;
    endcase
  end

  hex_to_seg7 u_dec (
    .nibble (disp_nib_s),
    .seg    (dec_seg_s)
  );

  assign seg_s = blank_s ? BLANK_SEG : dec_seg_s;

  // Output register: one edge behind the state that selects it
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      io_out_r <= 8'h00;
    end else begin
      io_out_r <= {full_s, seg_s};
    end
  end

  assign io_out = io_out_r;

endmodule

// File: tb/tb_seg7_digit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_seg7_digit_sequencer
// Table-driven bench for seg7_digit_sequencer with DEPTH=4, DWELL=4, GAP=2.
// Each vector gives the inputs held across one rising edge and the io_out
// expected just after that edge. Expected values go into a scoreboard queue
// when the vector is driven and are popped when the output is sampled on the
// following falling edge. Gap expectations follow SEQ_BLANK_GAP_EN.
// ---------------------------------------------------------------------------
module tb_seg7_digit_sequencer;

  localparam int DWELL_C = 4;
`ifdef SEQ_BLANK_GAP_EN
  localparam int PER_C = 6;
`else
  localparam int PER_C = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic       run;
  logic [3:0] nib;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {nib, run, wr, rst, clk};

  always #5 clk = ~clk;

  seg7_digit_sequencer #(
    .DEPTH (4),
    .DWELL (4)
`ifdef SEQ_BLANK_GAP_EN
    ,
    .GAP   (2)
`endif
  ) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic       run;
    logic [3:0] nib;
    logic       chk;
    logic [7:0] exp;
    int         id;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    int         id;
    int         idx;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_step = 0;

  // Digits 1..4 with full=1
  logic [7:0] scan_full [4] = '{8'h86, 8'hDB, 8'hCF, 8'hE6};
  // E, E, 1 with full=0
  logic [7:0] scan_ee1  [3] = '{8'h79, 8'h79, 8'h06};

  task automatic add(input logic r, input logic w, input logic rn,
                     input logic [3:0] n, input logic [7:0] e, input int id);
    vec_t v;
    v.rst = r; v.wr = w; v.run = rn; v.nib = n; v.chk = 1'b1; v.exp = e; v.id = id;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic w, input logic rn,
                      input logic [3:0] n, input logic c, input logic [7:0] e,
                      input int id);
    sb_t s;
    rst = r; wr = w; run = rn; nib = n;
    if (c) begin
      s.exp = e; s.id = id; s.idx = n_step;
      sb_q.push_back(s);
    end
    n_step++;
    @(posedge clk);
    @(negedge clk);
    if (c) begin
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty test%0d step%0d", id, n_step);
      end else begin
        s = sb_q.pop_front();
        n_cmp++;
        if (io_out !== s.exp) begin
          n_bad++;
          $display("FAIL test%0d step%0d io_out: got %02h, expected %02h",
                   s.id, s.idx, io_out, s.exp);
        end
      end
    end
  endtask

  initial begin
    int t;
    logic [7:0] e;

    // 1: reset with strobe held high, then release with strobe still high
    add(1'b1, 1'b1, 1'b0, 4'h7, 8'h00, 1);
    add(1'b1, 1'b1, 1'b0, 4'h7, 8'h00, 1);
    add(1'b0, 1'b1, 1'b0, 4'h7, 8'h00, 1);
    add(1'b0, 1'b1, 1'b0, 4'h7, 8'h00, 1);
    add(1'b0, 1'b0, 1'b0, 4'h7, 8'h00, 1);
    // 2: single write of 3 shows 4F two edges after sampling
    add(1'b0, 1'b1, 1'b0, 4'h3, 8'h00, 2);
    add(1'b0, 1'b0, 1'b0, 4'h0, 8'h4F, 2);
    // 3: reset, fill with 1..4, then an ignored 5th write
    add(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 3);
    add(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 3);
    add(1'b0, 1'b1, 1'b0, 4'h1, 8'h00, 3);
    add(1'b0, 1'b0, 1'b0, 4'h1, 8'h06, 3);
    add(1'b0, 1'b1, 1'b0, 4'h2, 8'h06, 3);
    add(1'b0, 1'b0, 1'b0, 4'h2, 8'h5B, 3);
    add(1'b0, 1'b1, 1'b0, 4'h3, 8'h5B, 3);
    add(1'b0, 1'b0, 1'b0, 4'h3, 8'h4F, 3);
    add(1'b0, 1'b1, 1'b0, 4'h4, 8'h4F, 3);
    add(1'b0, 1'b0, 1'b0, 4'h4, 8'hE6, 3);
    add(1'b0, 1'b1, 1'b0, 4'h5, 8'hE6, 3);
    add(1'b0, 1'b0, 1'b0, 4'h5, 8'hE6, 3);
    add(1'b0, 1'b0, 1'b0, 4'h0, 8'hE6, 3);
    // 4: scan all four digits, DWELL cycles each, through one full wrap
    add(1'b0, 1'b0, 1'b1, 4'h0, 8'hE6, 4);
    for (int s = 1; s <= 5 * PER_C + 2; s++) begin
      t = s - 1;
      e = ((t % PER_C) < DWELL_C) ? scan_full[(t / PER_C) % 4] : 8'h80;
      add(1'b0, 1'b0, 1'b1, 4'h0, e, 4);
    end
    // 5a: drop run mid-dwell on the second digit -> HOLD shows last (4)
    add(1'b0, 1'b0, 1'b0, 4'h0, 8'hDB, 5);
    add(1'b0, 1'b0, 1'b0, 4'h0, 8'hE6, 5);
    add(1'b0, 1'b0, 1'b0, 4'h0, 8'hE6, 5);
    // 5b: restart, then reset mid-SHOW; run is ignored once empty
    add(1'b0, 1'b0, 1'b1, 4'h0, 8'hE6, 5);
    add(1'b0, 1'b0, 1'b1, 4'h0, 8'h86, 5);
    add(1'b0, 1'b0, 1'b1, 4'h0, 8'h86, 5);
    add(1'b1, 1'b0, 1'b1, 4'h0, 8'h00, 5);
    add(1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 5);
    add(1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 5);
    // 6: write E, E and run
    add(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 6);
    add(1'b0, 1'b1, 1'b0, 4'hE, 8'h00, 6);
    add(1'b0, 1'b0, 1'b0, 4'hE, 8'h79, 6);
    add(1'b0, 1'b1, 1'b0, 4'hE, 8'h79, 6);
    add(1'b0, 1'b0, 1'b0, 4'hE, 8'h79, 6);
    add(1'b0, 1'b0, 1'b1, 4'h0, 8'h79, 6);
    for (int s = 1; s <= 14; s++) begin
      t = s - 1;
      e = ((t % PER_C) < DWELL_C) ? 8'h79 : 8'h00;
      add(1'b0, 1'b0, 1'b1, 4'h0, e, 6);
    end

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].run, vecs[i].nib,
           vecs[i].chk, vecs[i].exp, vecs[i].id);
    end

    // 7: a write while running is ignored; HOLD still shows E
    step(1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 8'h00, 7);
    step(1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 8'h00, 7);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 7);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h79, 7);
    // 8: a write while holding lands; buffer now E, E, 1
    step(1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 8'h00, 8);
    step(1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 8'h06, 8);
    // 9: three-digit scan must wrap at the fill count, not at DEPTH
    step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 8'h06, 9);
    for (int s = 1; s <= 4 * PER_C; s++) begin
      t = s - 1;
      e = ((t % PER_C) < DWELL_C) ? scan_ee1[(t / PER_C) % 3] : 8'h00;
      step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, e, 9);
    end

    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
